// File: rtl/sram_arbiter.sv
// Two-master to one-slave sram-like bus arbiter.
// Data side has priority over inst side. A request that the bus has not yet
// accepted keeps its owner locked until acceptance or until that owner drops
// its request. An in-order tag FIFO routes each bus response back to the
// master that issued it, with zero added latency.
module sram_arbiter #(
  parameter int unsigned DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     resetn,
  input  logic                     inst_req,
  input  logic                     inst_wr,
  input  logic [1:0]               inst_size,
  input  logic [31:0]              inst_addr,
  input  logic [3:0]               inst_wstrb,
  input  logic [31:0]              inst_wdata,
  output logic                     inst_addr_ok,
  output logic                     inst_data_ok,
  output logic [31:0]              inst_rdata,
  input  logic                     data_req,
  input  logic                     data_wr,
  input  logic [1:0]               data_size,
  input  logic [31:0]              data_addr,
  input  logic [3:0]               data_wstrb,
  input  logic [31:0]              data_wdata,
  output logic                     data_addr_ok,
  output logic                     data_data_ok,
  output logic [31:0]              data_rdata,
  output logic                     bus_req,
  output logic                     bus_wr,
  output logic [1:0]               bus_size,
  output logic [31:0]              bus_addr,
  output logic [3:0]               bus_wstrb,
  output logic [31:0]              bus_wdata,
  input  logic                     bus_addr_ok,
  input  logic                     bus_data_ok,
  input  logic [31:0]              bus_rdata,
  output logic [$clog2(DEPTH):0]   outstanding,
  output logic                     protocol_err
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = AW + 1;

  typedef enum logic {
    OWN_INST = 1'b0,
    OWN_DATA = 1'b1
  } owner_e;

  logic          lock_valid_q, lock_valid_d;
  owner_e        lock_owner_q, lock_owner_d;
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          perr_q, perr_d;
  owner_e        tags_q [DEPTH];

  logic   lock_hold;
  logic   sel_valid;
  owner_e sel_owner;
  logic   use_data;
  logic   full;
  logic   push;
  logic   pop;
  owner_e head_tag;

  // Lock only holds while the locked master keeps requesting; otherwise
  // selection falls back to fixed priority within the same cycle.
  assign lock_hold = lock_valid_q &&
                     ((lock_owner_q == OWN_DATA) ? data_req : inst_req);

  // Owner selection: held lock, then data side, then inst side.
  always_comb begin
    sel_valid = 1'b1;
    sel_owner = OWN_INST;
    if (lock_hold)     sel_owner = lock_owner_q;
    else if (data_req) sel_owner = OWN_DATA;
    else if (inst_req) sel_owner = OWN_INST;
    else               sel_valid = 1'b0;
  end

  assign full     = (cnt_q == CW'(DEPTH));
  assign use_data = sel_valid && (sel_owner == OWN_DATA);
  assign push     = bus_req && bus_addr_ok;
  assign pop      = bus_data_ok && (cnt_q != '0);
  assign head_tag = tags_q[rd_ptr_q];

  // Downstream request mux and per-side handshakes.
  always_comb begin
    bus_req      = sel_valid && !full;
    bus_wr       = use_data ? data_wr    : inst_wr;
    bus_size     = use_data ? data_size  : inst_size;
    bus_addr     = use_data ? data_addr  : inst_addr;
    bus_wstrb    = use_data ? data_wstrb : inst_wstrb;
    bus_wdata    = use_data ? data_wdata : inst_wdata;
    data_addr_ok = push && use_data;
    inst_addr_ok = push && !use_data;
    data_data_ok = pop && (head_tag == OWN_DATA);
    inst_data_ok = pop && (head_tag == OWN_INST);
    inst_rdata   = bus_rdata;
    data_rdata   = bus_rdata;
    outstanding  = cnt_q;
    protocol_err = perr_q;
  end

  // Next-state for lock, FIFO pointers, occupancy and error flag.
  always_comb begin
    lock_valid_d = lock_valid_q;
    lock_owner_d = lock_owner_q;
    if (bus_req) begin
      if (bus_addr_ok) begin
        lock_valid_d = 1'b0;
      end else begin
        lock_valid_d = 1'b1;
        lock_owner_d = sel_owner;
      end
    end else if (lock_valid_q && !lock_hold) begin
      lock_valid_d = 1'b0;
    end

    wr_ptr_d = push ? wr_ptr_q + 1'b1 : wr_ptr_q;
    rd_ptr_d = pop  ? rd_ptr_q + 1'b1 : rd_ptr_q;

    cnt_d = cnt_q;
    if (push && !pop)      cnt_d = cnt_q + 1'b1;
    else if (!push && pop) cnt_d = cnt_q - 1'b1;

    perr_d = perr_q || (bus_data_ok && (cnt_q == '0));
  end

  // State registers.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      lock_valid_q <= 1'b0;
      lock_owner_q <= OWN_INST;
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      cnt_q        <= '0;
      perr_q       <= 1'b0;
    end else begin
      lock_valid_q <= lock_valid_d;
      lock_owner_q <= lock_owner_d;
      wr_ptr_q     <= wr_ptr_d;
      rd_ptr_q     <= rd_ptr_d;
      cnt_q        <= cnt_d;
      perr_q       <= perr_d;
    end
  end

  // Tag storage: owner of each accepted request, in acceptance order.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      for (int unsigned i = 0; i < DEPTH; i++) tags_q[i] <= OWN_INST;
    end else if (push) begin
      tags_q[wr_ptr_q] <= sel_owner;
    end
  end

endmodule

// File: tb/tb_sram_arbiter.sv
// Directed testbench for sram_arbiter (DEPTH = 4).
module tb_sram_arbiter;

  logic        clk, resetn;
  logic        inst_req, inst_wr, data_req, data_wr;
  logic [1:0]  inst_size, data_size, bus_size;
  logic [31:0] inst_addr, inst_wdata, data_addr, data_wdata;
  logic [3:0]  inst_wstrb, data_wstrb, bus_wstrb;
  logic        inst_addr_ok, inst_data_ok, data_addr_ok, data_data_ok;
  logic [31:0] inst_rdata, data_rdata;
  logic        bus_req, bus_wr, bus_addr_ok, bus_data_ok;
  logic [31:0] bus_addr, bus_wdata, bus_rdata;
  logic [2:0]  outstanding;
  logic        protocol_err;

  int checks = 0;
  int failures = 0;

  sram_arbiter #(.DEPTH(4)) dut (
    .clk(clk), .resetn(resetn),
    .inst_req(inst_req), .inst_wr(inst_wr), .inst_size(inst_size),
    .inst_addr(inst_addr), .inst_wstrb(inst_wstrb), .inst_wdata(inst_wdata),
    .inst_addr_ok(inst_addr_ok), .inst_data_ok(inst_data_ok), .inst_rdata(inst_rdata),
    .data_req(data_req), .data_wr(data_wr), .data_size(data_size),
    .data_addr(data_addr), .data_wstrb(data_wstrb), .data_wdata(data_wdata),
    .data_addr_ok(data_addr_ok), .data_data_ok(data_data_ok), .data_rdata(data_rdata),
    .bus_req(bus_req), .bus_wr(bus_wr), .bus_size(bus_size),
    .bus_addr(bus_addr), .bus_wstrb(bus_wstrb), .bus_wdata(bus_wdata),
    .bus_addr_ok(bus_addr_ok), .bus_data_ok(bus_data_ok), .bus_rdata(bus_rdata),
    .outstanding(outstanding), .protocol_err(protocol_err)
  );

  always #5 clk = ~clk;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic idle;
    inst_req = 0; data_req = 0; bus_addr_ok = 0; bus_data_ok = 0;
    inst_wr = 0; data_wr = 0;
  endtask

  task automatic test_reset;
    resetn = 0; bus_data_ok = 1; inst_addr = 32'h1c000000; data_addr = 32'h1000;
    #1;
    checks++; if (outstanding !== 3'd0) begin failures++; $display("FAIL rst_outstanding: got %0d exp 0", outstanding); end
    checks++; if (protocol_err !== 1'b0) begin failures++; $display("FAIL rst_perr: got %b exp 0", protocol_err); end
    checks++; if (bus_req !== 1'b0) begin failures++; $display("FAIL rst_bus_req: got %b exp 0", bus_req); end
    checks++; if ({inst_data_ok, data_data_ok} !== 2'b00) begin failures++; $display("FAIL rst_data_ok: got %b exp 00", {inst_data_ok, data_data_ok}); end
    repeat (2) @(posedge clk);
    #1; bus_data_ok = 0; resetn = 1;
    tick;
    checks++; if ({bus_req, inst_addr_ok, data_addr_ok} !== 3'b000) begin failures++; $display("FAIL post_rst_idle: got %b exp 000", {bus_req, inst_addr_ok, data_addr_ok}); end
    checks++; if (protocol_err !== 1'b0) begin failures++; $display("FAIL post_rst_perr: got %b exp 0", protocol_err); end
  endtask

  task automatic test_priority;
    inst_req = 1; inst_addr = 32'h1c000000;
    data_req = 1; data_addr = 32'h00001000; data_wr = 1; data_wstrb = 4'hf;
    data_wdata = 32'hdeadbeef; data_size = 2'd2; bus_addr_ok = 1;
    #1;
    checks++; if (bus_addr !== 32'h00001000) begin failures++; $display("FAIL prio_bus_addr: got %h exp 00001000", bus_addr); end
    checks++; if ({bus_req, bus_wr, bus_size, bus_wstrb} !== {1'b1, 1'b1, 2'd2, 4'hf}) begin failures++; $display("FAIL prio_bus_ctl: got %b exp 1110 1111", {bus_req, bus_wr, bus_size, bus_wstrb}); end
    checks++; if (bus_wdata !== 32'hdeadbeef) begin failures++; $display("FAIL prio_wdata: got %h exp deadbeef", bus_wdata); end
    checks++; if ({data_addr_ok, inst_addr_ok} !== 2'b10) begin failures++; $display("FAIL prio_addr_ok: got %b exp 10", {data_addr_ok, inst_addr_ok}); end
    checks++; if (outstanding !== 3'd0) begin failures++; $display("FAIL prio_out_before: got %0d exp 0", outstanding); end
    tick; idle; #1;
    checks++; if (outstanding !== 3'd1) begin failures++; $display("FAIL prio_out_after: got %0d exp 1", outstanding); end
    bus_data_ok = 1; bus_rdata = 32'h12345678; #1;
    checks++; if ({data_data_ok, inst_data_ok} !== 2'b10) begin failures++; $display("FAIL prio_resp: got %b exp 10", {data_data_ok, inst_data_ok}); end
    checks++; if (data_rdata !== 32'h12345678 || inst_rdata !== 32'h12345678) begin failures++; $display("FAIL prio_rdata: got %h/%h exp 12345678", data_rdata, inst_rdata); end
    tick; idle; #1;
    checks++; if (outstanding !== 3'd0) begin failures++; $display("FAIL prio_drain: got %0d exp 0", outstanding); end
  endtask

  task automatic test_lock;
    inst_req = 1; inst_addr = 32'h1c000040; data_addr = 32'h00002000; bus_addr_ok = 0;
    #1;
    checks++; if (bus_req !== 1'b1 || bus_addr !== 32'h1c000040 || inst_addr_ok !== 1'b0) begin failures++; $display("FAIL lock_c0: got req=%b addr=%h ok=%b exp 1 1c000040 0", bus_req, bus_addr, inst_addr_ok); end
    tick; data_req = 1; #1;
    checks++; if (bus_addr !== 32'h1c000040) begin failures++; $display("FAIL lock_held_addr: got %h exp 1c000040", bus_addr); end
    checks++; if ({inst_addr_ok, data_addr_ok} !== 2'b00) begin failures++; $display("FAIL lock_held_ok: got %b exp 00", {inst_addr_ok, data_addr_ok}); end
    tick; bus_addr_ok = 1; #1;
    checks++; if ({inst_addr_ok, data_addr_ok} !== 2'b10) begin failures++; $display("FAIL lock_inst_acc: got %b exp 10", {inst_addr_ok, data_addr_ok}); end
    tick; inst_req = 0; #1;
    checks++; if (data_addr_ok !== 1'b1 || bus_addr !== 32'h00002000) begin failures++; $display("FAIL lock_data_acc: got ok=%b addr=%h exp 1 00002000", data_addr_ok, bus_addr); end
    tick; idle; #1;
    checks++; if (outstanding !== 3'd2) begin failures++; $display("FAIL lock_out: got %0d exp 2", outstanding); end
    bus_data_ok = 1; #1;
    checks++; if ({inst_data_ok, data_data_ok} !== 2'b10) begin failures++; $display("FAIL lock_resp0: got %b exp 10", {inst_data_ok, data_data_ok}); end
    tick;
    checks++; if ({inst_data_ok, data_data_ok} !== 2'b01) begin failures++; $display("FAIL lock_resp1: got %b exp 01", {inst_data_ok, data_data_ok}); end
    tick; idle; #1;
  endtask

  task automatic test_lock_release;
    inst_req = 1; bus_addr_ok = 0;
    tick;
    inst_req = 0; data_req = 1; #1;
    checks++; if (bus_req !== 1'b1 || bus_addr !== 32'h00002000) begin failures++; $display("FAIL rel_select: got req=%b addr=%h exp 1 00002000", bus_req, bus_addr); end
    bus_addr_ok = 1; #1;
    checks++; if ({data_addr_ok, inst_addr_ok} !== 2'b10) begin failures++; $display("FAIL rel_accept: got %b exp 10", {data_addr_ok, inst_addr_ok}); end
    tick; idle; bus_data_ok = 1; #1;
    checks++; if ({data_data_ok, inst_data_ok} !== 2'b10) begin failures++; $display("FAIL rel_resp: got %b exp 10", {data_data_ok, inst_data_ok}); end
    tick; idle; #1;
  endtask

  task automatic test_order;
    bus_addr_ok = 1; inst_req = 1; tick;
    inst_req = 0; data_req = 1; tick;
    data_req = 0; inst_req = 1; tick;
    idle; #1;
    checks++; if (outstanding !== 3'd3) begin failures++; $display("FAIL order_out3: got %0d exp 3", outstanding); end
    bus_data_ok = 1; bus_rdata = 32'haaaa0001; #1;
    checks++; if ({inst_data_ok, data_data_ok} !== 2'b10 || inst_rdata !== 32'haaaa0001) begin failures++; $display("FAIL order_A: got %b %h exp 10 aaaa0001", {inst_data_ok, data_data_ok}, inst_rdata); end
    tick;
    checks++; if (outstanding !== 3'd2) begin failures++; $display("FAIL order_out2: got %0d exp 2", outstanding); end
    bus_rdata = 32'hbbbb0002; #1;
    checks++; if ({inst_data_ok, data_data_ok} !== 2'b01 || data_rdata !== 32'hbbbb0002) begin failures++; $display("FAIL order_B: got %b %h exp 01 bbbb0002", {inst_data_ok, data_data_ok}, data_rdata); end
    tick; bus_rdata = 32'hcccc0003; #1;
    checks++; if ({inst_data_ok, data_data_ok} !== 2'b10 || inst_rdata !== 32'hcccc0003) begin failures++; $display("FAIL order_C: got %b %h exp 10 cccc0003", {inst_data_ok, data_data_ok}, inst_rdata); end
    tick; idle; #1;
    checks++; if (outstanding !== 3'd0) begin failures++; $display("FAIL order_out0: got %0d exp 0", outstanding); end
  endtask

  task automatic test_one_entry;
    data_req = 1; bus_addr_ok = 1; tick;
    data_req = 0; inst_req = 1; bus_data_ok = 1; #1;
    checks++; if ({data_data_ok, inst_data_ok, inst_addr_ok} !== 3'b101) begin failures++; $display("FAIL one_pushpop: got %b exp 101", {data_data_ok, inst_data_ok, inst_addr_ok}); end
    tick; inst_req = 0; bus_addr_ok = 0; #1;
    checks++; if (outstanding !== 3'd1) begin failures++; $display("FAIL one_out: got %0d exp 1", outstanding); end
    checks++; if ({data_data_ok, inst_data_ok} !== 2'b01) begin failures++; $display("FAIL one_tag: got %b exp 01", {data_data_ok, inst_data_ok}); end
    tick; idle; #1;
    checks++; if (outstanding !== 3'd0) begin failures++; $display("FAIL one_drain: got %0d exp 0", outstanding); end
  endtask

  task automatic test_full_wrap;
    bit exp_q[$];
    bit exp_tag;
    data_req = 1; bus_addr_ok = 1;
    repeat (4) tick;
    #1;
    checks++; if (outstanding !== 3'd4 || bus_req !== 1'b0 || data_addr_ok !== 1'b0) begin failures++; $display("FAIL full_block: got out=%0d req=%b ok=%b exp 4 0 0", outstanding, bus_req, data_addr_ok); end
    bus_data_ok = 1; #1;
    checks++; if ({bus_req, data_addr_ok, data_data_ok} !== 3'b001) begin failures++; $display("FAIL full_pop_noreq: got %b exp 001", {bus_req, data_addr_ok, data_data_ok}); end
    tick; bus_data_ok = 0; #1;
    checks++; if (outstanding !== 3'd3 || bus_req !== 1'b1 || data_addr_ok !== 1'b1) begin failures++; $display("FAIL full_resume: got out=%0d req=%b ok=%b exp 3 1 1", outstanding, bus_req, data_addr_ok); end
    tick; data_req = 0; bus_data_ok = 1; tick;
    exp_q = '{1'b1, 1'b1, 1'b1};
    for (int i = 0; i < 5; i++) begin
      inst_req = (i % 2 == 0); data_req = (i % 2 == 1); bus_addr_ok = 1; bus_data_ok = 1;
      exp_tag = exp_q.pop_front();
      exp_q.push_back(i % 2 == 1);
      #1;
      checks++; if ({data_data_ok, inst_data_ok} !== {exp_tag, !exp_tag} || outstanding !== 3'd3) begin failures++; $display("FAIL wrap_pp%0d: got ok=%b out=%0d exp %b 3", i, {data_data_ok, inst_data_ok}, outstanding, {exp_tag, !exp_tag}); end
      tick;
    end
    idle; bus_data_ok = 1;
    for (int i = 0; i < 3; i++) begin
      exp_tag = exp_q.pop_front();
      #1;
      checks++; if ({data_data_ok, inst_data_ok} !== {exp_tag, !exp_tag}) begin failures++; $display("FAIL wrap_drain%0d: got %b exp %b", i, {data_data_ok, inst_data_ok}, {exp_tag, !exp_tag}); end
      tick;
    end
    idle; #1;
    checks++; if (outstanding !== 3'd0 || protocol_err !== 1'b0) begin failures++; $display("FAIL wrap_end: got out=%0d perr=%b exp 0 0", outstanding, protocol_err); end
  endtask

  task automatic test_protocol_err;
    bus_data_ok = 1; #1;
    checks++; if ({inst_data_ok, data_data_ok} !== 2'b00) begin failures++; $display("FAIL perr_no_ok: got %b exp 00", {inst_data_ok, data_data_ok}); end
    tick; bus_data_ok = 0; #1;
    checks++; if (protocol_err !== 1'b1 || outstanding !== 3'd0) begin failures++; $display("FAIL perr_set: got perr=%b out=%0d exp 1 0", protocol_err, outstanding); end
    tick; tick;
    checks++; if (protocol_err !== 1'b1) begin failures++; $display("FAIL perr_sticky: got %b exp 1", protocol_err); end
    inst_req = 1; bus_addr_ok = 1; tick; idle; #1;
    checks++; if (outstanding !== 3'd1) begin failures++; $display("FAIL perr_pre_rst_out: got %0d exp 1", outstanding); end
    #2; resetn = 0; #1;
    checks++; if (protocol_err !== 1'b0 || outstanding !== 3'd0) begin failures++; $display("FAIL async_rst: got perr=%b out=%0d exp 0 0", protocol_err, outstanding); end
    @(posedge clk); #1; resetn = 1; tick;
    bus_data_ok = 1; #1;
    checks++; if ({inst_data_ok, data_data_ok} !== 2'b00) begin failures++; $display("FAIL stale_resp: got %b exp 00", {inst_data_ok, data_data_ok}); end
    tick; bus_data_ok = 0; #1;
    checks++; if (protocol_err !== 1'b1) begin failures++; $display("FAIL stale_perr: got %b exp 1", protocol_err); end
  endtask

  initial begin
    clk = 0; resetn = 0; idle;
    inst_size = 0; inst_wstrb = 0; inst_wdata = 0; inst_addr = 0;
    data_size = 0; data_wstrb = 0; data_wdata = 0; data_addr = 0; bus_rdata = 0;
    test_reset;
    test_priority;
    test_lock;
    test_lock_release;
    test_order;
    test_one_entry;
    test_full_wrap;
    test_protocol_err;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
